seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
- Reads a time-multiplexed seven-segment display bus (segment pattern plus one-hot digit strobes) and recovers one BCD value per digit position.
- It is the reading side of the display path: it rebuilds the digit values that the BCD-to-segment drive logic put on the segments.
- Used for display loopback checking and for capturing values from external seven-segment panels.
- Contains per-digit stability filtering, frame-completion tracking and error flagging.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 3, consecutive identical samples required before a digit is captured (1..15).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  8  segment bus: seg_in[6:0] = {a,b,c,d,e,f,g}, active-high; seg_in[7] (dp) is ignored.
- digit_sel  input  NUM_DIGITS  one-hot, active-high digit strobe; bit i selects digit i.
- bcd_out  output  4*NUM_DIGITS  digit i on bcd_out[4i+3:4i].
- digit_err  output  NUM_DIGITS  bit i = last capture of digit i was an undecodable pattern.
- frame_valid  output  1  one-cycle pulse: every digit captured at least once since the last pulse or reset.
- sel_err  output  1  high for one cycle after each edge that sampled a multi-hot digit_sel.

Behaviour:
- Reset: all outputs update asynchronously on rst.
  - Every bcd_out nibble = 4'hF.
  - digit_err = 0, frame_valid = 0, sel_err = 0.
  - Captured-mask = 0, stability counter = 0, FSM = IDLE.
  - Reset mid-frame discards the partial mask.
- Decode table (seg_in[6:0] -> BCD): 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 72->7, 7F->8, 7B->9.
  - Any other pattern -> nibble 4'hF and the digit's digit_err bit set.
  - A valid capture clears that digit_err bit.
- FSM states:
  - IDLE: digit_sel all-zero (blanking), or following a multi-hot sample.
  - SETTLE: counting consecutive samples with identical {digit_sel, seg_in[6:0]}.
  - CAPTURED: digit stored; no further capture until the pair changes.
- FSM transitions:
  - IDLE -> SETTLE: on a one-hot sample; counter = 1.
  - SETTLE, pair unchanged: counter increments.
  - SETTLE, pair changes to another one-hot value: counter restarts at 1 and state stays SETTLE.
  - SETTLE -> CAPTURED: on the edge where counter reaches STABLE_CYCLES. On that same edge, bcd_out nibble, digit_err bit and mask bit update.
  - With STABLE_CYCLES = 1, capture occurs on the first edge a one-hot pair is sampled.
  - CAPTURED, pair unchanged: hold; no recapture, no counting.
  - CAPTURED, pair changes: to SETTLE (counter = 1) if the new sample is one-hot; to IDLE otherwise.
- Any state, all-zero digit_sel: -> IDLE and counter = 0. No error is raised.
- Any state, multi-hot digit_sel: -> IDLE, counter = 0, sel_err = 1 in the following cycle. No capture.
- Latency: pattern stable before edge 1 and held through edge STABLE_CYCLES -> bcd_out valid after edge STABLE_CYCLES.
- Counter: saturates at STABLE_CYCLES; it never wraps.
- Frame tracking:
  - Mask bit i is set on capture of digit i.
  - Recapturing an already-set digit before frame completion overwrites bcd_out, and the mask is unchanged.
  - On the edge where a capture makes the mask all-ones, frame_valid is registered high for exactly one cycle and the mask clears to 0 on that same edge.
  - The completing capture does not count toward the next frame.
- Only seg_in[6:0] participates in the stability compare; a changing dp bit does not restart settling.

Test Plan:
- Reset, then digit_sel=0001 with seg=7E held for 3 edges, then 0010/30, 0100/6D, 1000/79 each for 3 edges -> bcd_out=16'h3210 and frame_valid one-cycle pulse after the 4th capture edge.
- Hold digit_sel=0001 with seg=5B for 2 edges, switch seg to 5F for 3 edges -> nibble0 stays F after the 2nd edge and becomes 6 after the 3rd 5F edge.
- digit_sel=0100 with seg=00 for 3 edges -> nibble2 = F, digit_err=0100. Then 0100/7F for 3 edges -> nibble2 = 8, digit_err=0000.
- digit_sel=0011 for 1 edge -> sel_err high for exactly one cycle, no bcd_out change, no mask change. digit_sel=0000 -> no sel_err.
- Capture digits 0..2, assert rst mid-SETTLE of digit 3 -> all nibbles F immediately. Then a full 4-digit scan is required before frame_valid pulses.
- Hold 0001/30 for 10 edges -> exactly one capture, and the mask bit does not double-count toward frame_valid.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan reader: recovers BCD digits from a multiplexed
// segment bus with per-digit settling, frame tracking and error flags.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  localparam int          PW       = NUM_DIGITS + 7;
  localparam logic [3:0]  STABLE_C = 4'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [PW-1:0]             pair_q, pair_d;
  logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]     err_q, err_d;
  logic [NUM_DIGITS-1:0]     mask_q, mask_d;
  logic                      fv_q, fv_d;
  logic                      se_q, se_d;

  logic                      sel_zero;
  logic                      sel_multi;
  logic                      same;
  logic                      capture;
  logic [4:0]                dec;

  // {bad, nibble}: bad set for any pattern outside the digit table
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'h7E:   r = 5'h00;
      7'h30:   r = 5'h01;
      7'h6D:   r = 5'h02;
      7'h79:   r = 5'h03;
      7'h33:   r = 5'h04;
      7'h5B:   r = 5'h05;
      7'h5F:   r = 5'h06;
      7'h72:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h7B:   r = 5'h09;
      default: r = 5'h1F;
    endcase
    return r;
  endfunction

  // Strobe classification and segment decode of the current sample
  always_comb begin
    sel_zero  = (digit_sel == '0);
    sel_multi = ((digit_sel & (digit_sel - SEL_ONE)) != '0);
    dec       = decode(seg_in[6:0]);
  end

  // Settling FSM, capture into the digit registers, frame completion
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    err_d   = err_q;
    mask_d  = mask_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    capture = 1'b0;
    pair_d  = {digit_sel, seg_in[6:0]};
    same    = (pair_d == pair_q);

    if (sel_zero) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (sel_multi) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      se_d    = 1'b1;
    end else if (!(state_q == CAPTURED && same)) begin
      if (state_q == SETTLE && same) begin
        cnt_d = (cnt_q < STABLE_C) ? cnt_q + 4'd1 : cnt_q;
      end else begin
        cnt_d = 4'd1;
      end
      state_d = SETTLE;
      if (cnt_d == STABLE_C) begin
        capture = 1'b1;
        state_d = CAPTURED;
      end
    end

    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digit_sel[i]) begin
          bcd_d[4*i +: 4] = dec[3:0];
          err_d[i]        = dec[4];
          mask_d[i]       = 1'b1;
        end
      end
      if (&mask_d) begin
        fv_d   = 1'b1;
        mask_d = '0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pair_q  <= '0;
      bcd_q   <= '1;
      err_q   <= '0;
      mask_q  <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      bcd_q   <= bcd_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign sel_err     = se_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: vector table plus
// hand sequences for hold, dp, and mid-frame reset.
module tb_seven_seg_scan_decoder;

  logic        clk;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  digit_sel;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        sel_err;

  int n_chk;
  int n_pass;

  seven_seg_scan_decoder #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .digit_sel(digit_sel),
    .bcd_out(bcd_out),
    .digit_err(digit_err),
    .frame_valid(frame_valid),
    .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  seg;
    int          n;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        fv;
    logic        se;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic [15:0] b,
                         input logic [3:0] e, input logic f,
                         input logic s);
    chk({nm, ".bcd"}, 32'(bcd_out), 32'(b));
    chk({nm, ".err"}, 32'(digit_err), 32'(e));
    chk({nm, ".fv"}, 32'(frame_valid), 32'(f));
    chk({nm, ".se"}, 32'(sel_err), 32'(s));
  endtask

  task automatic run(input logic [3:0] sel, input logic [7:0] seg,
                     input int n);
    @(negedge clk);
    digit_sel = sel;
    seg_in    = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    seg_in    = 8'h00;
    digit_sel = 4'h0;

    tbl[0]  = '{4'b0001, 8'h7E, 3, 16'hFFF0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 8'h30, 3, 16'hFF10, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0100, 8'h6D, 3, 16'hF210, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1000, 8'h79, 3, 16'h3210, 4'h0, 1'b1, 1'b0};
    tbl[4]  = '{4'b0000, 8'h00, 1, 16'h3210, 4'h0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0001, 8'h5B, 2, 16'h3210, 4'h0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0001, 8'h5F, 3, 16'h3216, 4'h0, 1'b0, 1'b0};
    tbl[7]  = '{4'b0100, 8'h00, 3, 16'h3F16, 4'h4, 1'b0, 1'b0};
    tbl[8]  = '{4'b0100, 8'h7F, 3, 16'h3816, 4'h0, 1'b0, 1'b0};
    tbl[9]  = '{4'b0011, 8'h7E, 1, 16'h3816, 4'h0, 1'b0, 1'b1};
    tbl[10] = '{4'b0000, 8'h7E, 1, 16'h3816, 4'h0, 1'b0, 1'b0};
    tbl[11] = '{4'b1000, 8'h79, 3, 16'h3816, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{4'b0010, 8'h30, 3, 16'h3816, 4'h0, 1'b1, 1'b0};
    tbl[13] = '{4'b0000, 8'h00, 1, 16'h3816, 4'h0, 1'b0, 1'b0};

    #12;
    chk_all("reset", 16'hFFFF, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run(tbl[i].sel, tbl[i].seg, tbl[i].n);
      chk_all($sformatf("vec%0d", i), tbl[i].bcd, tbl[i].err,
              tbl[i].fv, tbl[i].se);
    end

    // dp toggling must not restart settling
    @(negedge clk);
    digit_sel = 4'b0001;
    seg_in    = 8'h33;
    @(posedge clk);
    @(negedge clk);
    seg_in = 8'hB3;
    @(posedge clk);
    @(negedge clk);
    seg_in = 8'h33;
    @(posedge clk);
    #1;
    chk_all("dp", 16'h3814, 4'h0, 1'b0, 1'b0);

    // long hold on digit 1: one capture, no frame pulse
    @(negedge clk);
    digit_sel = 4'b0010;
    seg_in    = 8'h30;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d.fv", k), 32'(frame_valid), 32'd0);
    end
    chk("hold.bcd", 32'(bcd_out), 32'h3814);
    run(4'b0100, 8'h6D, 3);
    chk_all("hold_d2", 16'h3214, 4'h0, 1'b0, 1'b0);
    run(4'b1000, 8'h79, 3);
    chk_all("hold_d3", 16'h3214, 4'h0, 1'b1, 1'b0);

    // partial frame then reset mid-settle of digit 3
    run(4'b0001, 8'h7E, 3);
    run(4'b0010, 8'h30, 3);
    run(4'b0100, 8'h6D, 3);
    chk_all("pre_rst", 16'h3210, 4'h0, 1'b0, 1'b0);
    run(4'b1000, 8'h79, 2);
    #1;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 16'hFFFF, 4'h0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    run(4'b1000, 8'h79, 3);
    chk_all("post_d3", 16'h3FFF, 4'h0, 1'b0, 1'b0);
    run(4'b0001, 8'h7E, 3);
    chk_all("post_d0", 16'h3FF0, 4'h0, 1'b0, 1'b0);
    run(4'b0010, 8'h30, 3);
    chk_all("post_d1", 16'h3F10, 4'h0, 1'b0, 1'b0);
    run(4'b0100, 8'h6D, 3);
    chk_all("post_d2", 16'h3210, 4'h0, 1'b1, 1'b0);
    run(4'b0100, 8'h6D, 1);
    chk("post_end.fv", 32'(frame_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
